// File: rtl/serial_bit_source_if.sv
// Word-in / bit-out bus of the serial bit source.
// The slave side is the serializer; the master side supplies words and
// watches the serial stream.
interface serial_bit_source_if #(
    parameter int WIDTH = 8
) ();
    localparam int IW = $clog2(WIDTH);

    logic             load;
    logic [WIDTH-1:0] data_in;
    logic             loop;
    logic             I;
    logic             valid;
    logic             ready;
    logic             done;
    logic [IW-1:0]    idx;

    modport master (
        output load, data_in, loop,
        input  I, valid, ready, done, idx
    );

    modport slave (
        input  load, data_in, loop,
        output I, valid, ready, done, idx
    );
endinterface

// File: rtl/serial_bit_source.sv
// Parallel-to-serial bit-stream source.
// Accepts a WIDTH-bit word on a ready/load handshake and plays it out one bit
// per clock, MSB-first or LSB-first. A new word may be loaded during the last
// bit, so consecutive words follow each other with no gap. With loop held in
// the last-bit cycle, the saved word is replayed.
module serial_bit_source #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b0,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic              clock,
    input  logic              reset,
    serial_bit_source_if.slave bus
);
    localparam int            IW   = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] shift_reg, shift_next;
    logic [WIDTH-1:0] word_reg,  word_next;
    logic [IW-1:0]    idx_reg,   idx_next;

    logic             last_bit;
    logic             head_bit;
    logic [WIDTH-1:0] shifted;

    // The bit order only changes which end of the register is shown and
    // which way it moves.
    generate
        if (LSB_FIRST) begin : g_lsb
            assign head_bit = shift_reg[0];
            assign shifted  = {1'b0, shift_reg[WIDTH-1:1]};
        end else begin : g_msb
            assign head_bit = shift_reg[WIDTH-1];
            assign shifted  = {shift_reg[WIDTH-2:0], 1'b0};
        end
    endgenerate

    assign last_bit  = (state_reg == SHIFT) && (idx_reg == LAST);

    // Every output comes from registered state only; nothing passes
    // straight from an input to an output.
    assign bus.valid = (state_reg == SHIFT);
    assign bus.ready = (state_reg == IDLE) || last_bit;
    assign bus.done  = last_bit;
    assign bus.I     = (state_reg == SHIFT) ? head_bit : IDLE_BIT;
    assign bus.idx   = idx_reg;

    // State register; reset abandons any word in flight and clears the
    // datapath.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg <= IDLE;
            shift_reg <= '0;
            word_reg  <= '0;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            shift_reg <= shift_next;
            word_reg  <= word_next;
            idx_reg   <= idx_next;
        end
    end

    // Next-state logic. In the last-bit cycle a new load beats loop, and
    // loop beats returning to idle.
    always_comb begin
        state_next = state_reg;
        shift_next = shift_reg;
        word_next  = word_reg;
        idx_next   = idx_reg;

        case (state_reg)
            IDLE: begin
                idx_next = '0;
                if (bus.load) begin
                    state_next = SHIFT;
                    shift_next = bus.data_in;
                    word_next  = bus.data_in;
                end
            end

            SHIFT: begin
                if (!last_bit) begin
                    shift_next = shifted;
                    idx_next   = idx_reg + IW'(1);
                end else if (bus.load) begin
                    shift_next = bus.data_in;
                    word_next  = bus.data_in;
                    idx_next   = '0;
                end else if (bus.loop) begin
                    // Replay from the saved copy. The shift register has
                    // already lost those bits.
                    shift_next = word_reg;
                    idx_next   = '0;
                end else begin
                    state_next = IDLE;
                    idx_next   = '0;
                end
            end

            default: begin
                state_next = IDLE;
                idx_next   = '0;
            end
        endcase
    end
endmodule

// File: tb/tb_serial_bit_source.sv
// Testbench for serial_bit_source.
// Two instances, one MSB-first with idle 0 and one LSB-first with idle 1, get
// the same stimulus. Each accepted word is expanded into its expected bit
// stream and queued. A negedge monitor pops one entry per valid cycle.
module tb_serial_bit_source;
    localparam int W  = 5;
    localparam int IW = $clog2(W);

    typedef struct {
        logic b;
        logic d;
        int   ix;
    } exp_t;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;
    bit   mon_en;

    exp_t qm[$];
    exp_t ql[$];

    // Reference model state: bits of the current word still to show,
    // counting the one on the wire in the current cycle.
    int             left;
    logic [W-1:0]   cur_word;
    bit             flush_pending;

    serial_bit_source_if #(.WIDTH(W)) ifm ();
    serial_bit_source_if #(.WIDTH(W)) ifl ();

    serial_bit_source #(.WIDTH(W), .LSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_m (
        .clock (clk),
        .reset (rst_n),
        .bus   (ifm)
    );

    serial_bit_source #(.WIDTH(W), .LSB_FIRST(1'b1), .IDLE_BIT(1'b1)) dut_l (
        .clock (clk),
        .reset (rst_n),
        .bus   (ifl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expand a word into its bit sequence for both bit orders.
    task automatic push_word(input logic [W-1:0] w);
        exp_t em;
        exp_t el;
        for (int j = 0; j < W; j++) begin
            em.b  = w[W-1-j];
            el.b  = w[j];
            em.d  = (j == W - 1);
            el.d  = (j == W - 1);
            em.ix = j;
            el.ix = j;
            qm.push_back(em);
            ql.push_back(el);
        end
    endtask

    // Check one instance's serial outputs for the current cycle.
    task automatic chk(input int which, input logic i, input logic v, input logic d,
                       input logic [IW-1:0] ix);
        exp_t e;
        logic idle_b;
        int   qsize;
        idle_b = (which == 1);
        qsize  = (which == 0) ? qm.size() : ql.size();
        if (v === 1'b1) begin
            if (qsize == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_valid dut%0d: got valid=1, expected valid=0 at %0t",
                         which, $time);
            end else begin
                e = (which == 0) ? qm.pop_front() : ql.pop_front();
                cmp(which == 0 ? "bit_m"  : "bit_l",  32'(i),  32'(e.b));
                cmp(which == 0 ? "done_m" : "done_l", 32'(d),  32'(e.d));
                cmp(which == 0 ? "idx_m"  : "idx_l",  32'(ix), 32'(e.ix));
                if (e.d)
                    $display("[TB] dut%0d word complete at %0t", which, $time);
            end
        end else begin
            cmp(which == 0 ? "idle_bit_m"  : "idle_bit_l",  32'(i),  32'(idle_b));
            cmp(which == 0 ? "idle_done_m" : "idle_done_l", 32'(d),  32'(0));
            cmp(which == 0 ? "idle_idx_m"  : "idle_idx_l",  32'(ix), 32'(0));
        end
    endtask

    // Monitor: samples both instances on the falling edge.
    always @(negedge clk) begin
        if (mon_en) begin
            chk(0, ifm.I, ifm.valid, ifm.done, ifm.idx);
            chk(1, ifl.I, ifl.valid, ifl.done, ifl.idx);
        end
    end

    // One clock of stimulus. Inputs are driven just after the edge and take
    // effect on the next edge. The model decides acceptance from its own
    // count of remaining bits.
    task automatic cycle(input bit rn, input bit ld, input logic [W-1:0] d, input bit lp);
        bit accept;
        @(posedge clk);
        #1;
        if (flush_pending) begin
            qm.delete();
            ql.delete();
            flush_pending = 1'b0;
        end
        rst_n       = rn;
        ifm.load    = ld;
        ifl.load    = ld;
        ifm.data_in = d;
        ifl.data_in = d;
        ifm.loop    = lp;
        ifl.loop    = lp;
        cmp("ready_m", 32'(ifm.ready), 32'(left <= 1));
        cmp("ready_l", 32'(ifl.ready), 32'(left <= 1));
        cmp("valid_m", 32'(ifm.valid), 32'(left > 0));
        cmp("valid_l", 32'(ifl.valid), 32'(left > 0));
        accept = ld && (left <= 1);
        if (!rn) begin
            left          = 0;
            flush_pending = 1'b1;
        end else if (accept) begin
            cur_word = d;
            push_word(d);
            left = W;
        end else if (left == 1 && lp) begin
            push_word(cur_word);
            left = W;
        end else if (left > 0) begin
            left--;
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) cycle(1'b1, 1'b0, 5'b00000, 1'b0);
    endtask

    initial begin
        tests         = 0;
        fails         = 0;
        mon_en        = 1'b0;
        left          = 0;
        cur_word      = '0;
        flush_pending = 1'b0;
        rst_n         = 1'b0;
        ifm.load = 1'b0; ifm.data_in = '0; ifm.loop = 1'b0;
        ifl.load = 1'b0; ifl.data_in = '0; ifl.loop = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Reset held, with load asserted, must stay idle.
        cycle(1'b0, 1'b1, 5'b10101, 1'b0);
        // Load in the first cycle after release is accepted.
        cycle(1'b1, 1'b1, 5'b11001, 1'b0);
        idle_cycles(7);

        // Back-to-back: second word loaded in the done cycle.
        cycle(1'b1, 1'b1, 5'b11001, 1'b0);
        idle_cycles(4);
        cycle(1'b1, 1'b1, 5'b00111, 1'b0);
        idle_cycles(7);

        // Loop held for three words, then dropped.
        cycle(1'b1, 1'b1, 5'b10110, 1'b1);
        for (int k = 0; k < 14; k++) cycle(1'b1, 1'b0, 5'b00000, 1'b1);
        idle_cycles(7);

        // Load at idx=2 is ignored.
        cycle(1'b1, 1'b1, 5'b11001, 1'b0);
        idle_cycles(2);
        cycle(1'b1, 1'b1, 5'b00000, 1'b0);
        idle_cycles(6);

        // Reset at idx=3 with load in the same cycle.
        cycle(1'b1, 1'b1, 5'b11001, 1'b0);
        idle_cycles(3);
        cycle(1'b0, 1'b1, 5'b11111, 1'b0);
        idle_cycles(4);

        // Random traffic.
        for (int k = 0; k < 1500; k++) begin
            logic [W-1:0] d;
            bit           rn;
            bit           ld;
            bit           lp;
            d  = W'($urandom);
            rn = ($urandom_range(0, 60) != 0);
            ld = ($urandom_range(0, 3) == 0);
            lp = ($urandom_range(0, 2) == 0);
            cycle(rn, ld, d, lp);
        end

        // Drain, then every queued bit must have been seen.
        idle_cycles(W + 3);
        @(negedge clk);
        #1;
        cmp("drain_m", 32'(qm.size()), 32'(0));
        cmp("drain_l", 32'(ql.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
